// File: rtl/conv_layer_scheduler_pkg.sv
// conv_layer_scheduler_pkg: shared FSM encoding, descriptor layout and table depth.
package conv_layer_scheduler_pkg;
    localparam int MAX_LAYERS = 8;
    localparam int DESC_W = 40;
    localparam int TL_LSB = 0, TL_W = 10;
    localparam int FN_LSB = 10, FN_W = 10;
    localparam int IC_LSB = 20, IC_W = 10;
    localparam int KS_LSB = 30, KS_W = 5;
    localparam int PAD_LSB = 35, PAD_W = 3;
    localparam int STR_LSB = 38, STR_W = 2;
    typedef enum logic [2:0] {IDLE, CLR, CFG, GO, RUN, WREQ, NEXT, FIN} state_t;
endpackage

// File: rtl/layer_desc_regfile.sv
// layer_desc_regfile: descriptor table, one write port and one asynchronous read port.
module layer_desc_regfile
    import conv_layer_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DESC_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DESC_W-1:0] rdata
);
    logic [DESC_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: steps the 1D-conv control through a table of layer descriptors,
// brokering weight reloads with the DMA between start_whole and done_all.
module conv_layer_scheduler #(
    parameter int MAX_LAYERS = conv_layer_scheduler_pkg::MAX_LAYERS,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [39:0]      cfg_data,
    input  logic [IDX_W:0]   num_layers,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] cur_layer,
    output logic [9:0]       filters_done,
    output logic [1:0]       stride,
    output logic [2:0]       padding,
    output logic [4:0]       kernel_size,
    output logic [9:0]       input_channels,
    output logic [9:0]       filter_number,
    output logic [9:0]       temporal_length,
    output logic             conv_rst_n,
    output logic             start_whole,
    input  logic             done_all,
    input  logic             done_filter,
    input  logic             weight_req_top,
    output logic             weight_ack_top,
    output logic             dma_req,
    output logic [IDX_W-1:0] dma_layer,
    input  logic             dma_ack
);
    import conv_layer_scheduler_pkg::*;
    localparam logic [IDX_W:0] MAXV = (IDX_W+1)'(MAX_LAYERS);
    state_t state, state_n;
    logic [IDX_W:0] n_layers, next_idx;
    logic [DESC_W-1:0] desc;
    logic wreq_q, aborted, kill;
    assign kill = abort && state != IDLE;
    assign next_idx = {1'b0, cur_layer} + (IDX_W+1)'(1);
    assign busy = state != IDLE;
    assign start_whole = state == GO;
    // aborted stretches the conv reset into the cycle after an abort
    assign conv_rst_n = !(rst || state == CLR || aborted);

    layer_desc_regfile #(.DEPTH(MAX_LAYERS), .AW(IDX_W)) u_table (
        .clk(clk), .we(cfg_we && state == IDLE), .waddr(cfg_addr), .wdata(cfg_data),
        .raddr(cur_layer), .rdata(desc)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = num_layers == '0 ? FIN : CLR;
            CLR:  state_n = CFG;
            CFG:  state_n = GO;
            GO:   state_n = RUN;
            RUN:  state_n = done_all ? NEXT : (weight_req_top && !wreq_q) ? WREQ : RUN;
            WREQ: state_n = dma_ack ? RUN : WREQ;
            NEXT: state_n = next_idx == n_layers ? FIN : CLR;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n_layers <= '0;
            cur_layer <= '0;
            filters_done <= '0;
            {stride, padding, kernel_size, input_channels, filter_number, temporal_length} <= '0;
            done <= 1'b0;
            weight_ack_top <= 1'b0;
            dma_req <= 1'b0;
            dma_layer <= '0;
            wreq_q <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state <= state_n;
            wreq_q <= weight_req_top;
            aborted <= kill;
            done <= state == FIN && !kill;
            weight_ack_top <= state == WREQ && dma_ack && !kill;
            if (state == IDLE && start) begin
                n_layers <= num_layers > MAXV ? MAXV : num_layers;
                cur_layer <= '0;
            end
            if (state == NEXT && state_n == CLR) cur_layer <= next_idx[IDX_W-1:0];
            if (state == CLR) filters_done <= '0;
            else if ((state == RUN || state == WREQ) && done_filter && filters_done != 10'h3ff)
                filters_done <= filters_done + 10'd1;
            if (state == CFG) begin
                stride <= desc[STR_LSB +: STR_W];
                padding <= desc[PAD_LSB +: PAD_W];
                kernel_size <= desc[KS_LSB +: KS_W];
                input_channels <= desc[IC_LSB +: IC_W];
                filter_number <= desc[FN_LSB +: FN_W];
                temporal_length <= desc[TL_LSB +: TL_W];
            end
            if (state == RUN && state_n == WREQ) begin
                dma_req <= 1'b1;
                dma_layer <= cur_layer;
            end else if (kill || (state == WREQ && dma_ack)) dma_req <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb_conv_layer_scheduler: table-driven, randomized and hand-sequenced checks of the layer scheduler.
`timescale 1ns/1ps
module tb_conv_layer_scheduler;
    localparam int ML = 8, IW = 3;
    logic clk = 0, rst = 1, cfg_we = 0, start = 0, abort = 0;
    logic done_all = 0, done_filter = 0, weight_req_top = 0, dma_ack = 0;
    logic [IW-1:0] cfg_addr = '0;
    logic [39:0] cfg_data = '0;
    logic [IW:0] num_layers = '0;
    logic busy, done, conv_rst_n, start_whole, weight_ack_top, dma_req;
    logic [IW-1:0] cur_layer, dma_layer;
    logic [9:0] filters_done, input_channels, filter_number, temporal_length;
    logic [1:0] stride;
    logic [2:0] padding;
    logic [4:0] kernel_size;
    int total = 0, bad = 0, cyc = 0;
    int sw_cnt = 0, done_cnt = 0, rlow_cnt = 0, req_cnt = 0, ack_cnt = 0;
    logic [39:0] mdl [ML];

    typedef struct {int n; int len; int sw; int dcyc;} vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    conv_layer_scheduler #(.MAX_LAYERS(ML), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .num_layers(num_layers), .start(start), .abort(abort), .busy(busy), .done(done),
        .cur_layer(cur_layer), .filters_done(filters_done), .stride(stride), .padding(padding),
        .kernel_size(kernel_size), .input_channels(input_channels), .filter_number(filter_number),
        .temporal_length(temporal_length), .conv_rst_n(conv_rst_n), .start_whole(start_whole),
        .done_all(done_all), .done_filter(done_filter), .weight_req_top(weight_req_top),
        .weight_ack_top(weight_ack_top), .dma_req(dma_req), .dma_layer(dma_layer), .dma_ack(dma_ack)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sw_cnt += int'(start_whole);
        done_cnt += int'(done);
        rlow_cnt += int'(!conv_rst_n);
        req_cnt += int'(dma_req);
        ack_cnt += int'(weight_ack_top);
    endtask

    task automatic clr();
        sw_cnt = 0; done_cnt = 0; rlow_cnt = 0; req_cnt = 0; ack_cnt = 0;
    endtask

    task automatic wr(input int a, input logic [39:0] d);
        cfg_we = 1; cfg_addr = a[IW-1:0]; cfg_data = d;
        tick();
        cfg_we = 0;
        mdl[a] = d;
    endtask

    function automatic logic [39:0] mk(int s, int p, int k, int ic, int fn, int tl);
        return {s[1:0], p[2:0], k[4:0], ic[9:0], fn[9:0], tl[9:0]};
    endfunction

    function automatic int exp_done(int n, int lens [ML]);
        int eff = n > ML ? ML : n;
        int t = 3;
        if (eff == 0) return 2;
        for (int i = 0; i < eff - 1; i++) t += lens[i] + 4;
        return t + lens[eff-1] + 3;
    endfunction

    task automatic wait_evt(input string name, input bit on_done);
        bit hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            tick();
            hit = on_done ? done : start_whole;
        end
        chk(name, hit, 1);
    endtask

    // Drives a full run: done_all arrives lens[l] cycles after each start_whole.
    task automatic run(input int n, input int lens [ML], input bit rnd, output int sw, output int rl, output int dcyc);
        int t0, layer, da_at, g, fcnt;
        clr();
        num_layers = n[IW:0]; start = 1; t0 = cyc;
        tick();
        start = 0; layer = 0; da_at = -1; g = -1; dcyc = -1; fcnt = 0;
        for (int k = 0; k < 600 && dcyc < 0; k++) begin
            if (start_whole) begin
                chk("cur_layer", cur_layer, layer);
                chk("params", {stride, padding, kernel_size, input_channels, filter_number, temporal_length}, mdl[layer % ML]);
                chk("busy in run", busy, 1);
                g = cyc; da_at = cyc + lens[layer % ML]; fcnt = 0; layer++;
            end
            if (done) dcyc = cyc - t0;
            done_all = cyc == da_at;
            if (done_all) chk("filters_done", filters_done, fcnt);
            done_filter = rnd && g >= 0 && cyc > g && cyc < da_at && $urandom_range(0, 1) == 1;
            fcnt += int'(done_filter);
            start = rnd && $urandom_range(0, 3) == 0;
            if (dcyc < 0) tick();
        end
        done_all = 0; done_filter = 0; start = 0;
        chk("done pulses", done_cnt, 1);
        if (dcyc >= 0) chk("idle at done", busy, 0);
        sw = sw_cnt; rl = rlow_cnt;
    endtask

    initial begin
        int lens [ML];
        int sw, rl, d, n, eff, r;
        vecs[0] = '{2, 3, 2, 16};
        vecs[1] = '{0, 1, 0, 2};
        vecs[2] = '{1, 1, 1, 7};
        vecs[3] = '{2, 2, 2, 14};
        vecs[4] = '{3, 1, 3, 17};
        vecs[5] = '{8, 3, 8, 58};
        vecs[6] = '{9, 1, 8, 42};
        vecs[7] = '{15, 2, 8, 50};

        repeat (3) tick();
        chk("conv_rst_n in reset", conv_rst_n, 0);
        rst = 0;
        tick();
        chk("conv_rst_n after reset", conv_rst_n, 1);
        chk("reset outputs", {busy, done, cur_layer, filters_done, start_whole, weight_ack_top, dma_req, dma_layer}, 0);
        chk("reset params", {stride, padding, kernel_size, input_channels, filter_number, temporal_length}, 0);

        abort = 1;
        tick();
        abort = 0;
        tick();
        chk("idle abort busy", busy, 0);
        chk("idle abort conv_rst_n", conv_rst_n, 1);

        for (int i = 0; i < ML; i++) wr(i, {$urandom, $urandom} & 40'hff_ffff_ffff);
        wr(0, mk(1, 2, 5, 16, 4, 100));
        wr(1, mk(2, 1, 3, 32, 8, 50));

        foreach (vecs[i]) begin
            foreach (lens[j]) lens[j] = vecs[i].len;
            run(vecs[i].n, lens, 0, sw, rl, d);
            chk($sformatf("vec%0d start_whole", i), sw, vecs[i].sw);
            chk($sformatf("vec%0d conv_rst_n lows", i), rl, vecs[i].sw);
            chk($sformatf("vec%0d done cycle", i), d, vecs[i].dcyc);
            tick();
        end

        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 11);
            eff = n > ML ? ML : n;
            foreach (lens[j]) lens[j] = $urandom_range(1, 6);
            run(n, lens, 1, sw, rl, d);
            chk("rand start_whole", sw, eff);
            chk("rand conv_rst_n lows", rl, eff);
            chk("rand done cycle", d, exp_done(n, lens));
            tick();
        end

        // weight reload in layer 1 with a 10-cycle DMA
        clr();
        num_layers = 2; start = 1;
        tick();
        start = 0;
        wait_evt("wait sw0", 0);
        tick();
        done_all = 1;
        tick();
        done_all = 0;
        wait_evt("wait sw1", 0);
        chk("layer1 index", cur_layer, 1);
        tick();
        weight_req_top = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            dma_ack = i == 10;
            if (i <= 10) begin
                chk("dma_req held", dma_req, 1);
                chk("dma_layer", dma_layer, 1);
            end
            if (i == 11) begin
                chk("dma_req dropped", dma_req, 0);
                chk("weight_ack_top", weight_ack_top, 1);
            end
        end
        chk("dma_req cycles", req_cnt, 10);
        chk("weight_ack pulses", ack_cnt, 1);
        weight_req_top = 0;
        tick();
        done_all = 1;
        tick();
        done_all = 0;
        wait_evt("reload run done", 1);
        tick();

        // weight request coincident with done_all
        clr();
        num_layers = 1; start = 1;
        tick();
        start = 0;
        wait_evt("wait sw coincide", 0);
        r = cyc;
        tick();
        weight_req_top = 1; done_all = 1;
        tick();
        weight_req_top = 0; done_all = 0;
        chk("coincide no dma_req", dma_req, 0);
        tick();
        tick();
        chk("coincide done", done, 1);
        chk("coincide done cycle", cyc - r, 4);
        chk("coincide dma cycles", req_cnt, 0);
        tick();

        // abort while waiting on the DMA
        clr();
        num_layers = 2; start = 1;
        tick();
        start = 0;
        wait_evt("wait sw abort", 0);
        tick();
        weight_req_top = 1;
        repeat (3) tick();
        chk("in wreq", dma_req, 1);
        abort = 1;
        tick();
        abort = 0;
        chk("abort dma_req", dma_req, 0);
        chk("abort conv_rst_n low", conv_rst_n, 0);
        chk("abort busy", busy, 0);
        tick();
        chk("abort conv_rst_n back", conv_rst_n, 1);
        weight_req_top = 0;
        repeat (8) tick();
        chk("abort no done", done_cnt, 0);
        foreach (lens[j]) lens[j] = 1;
        run(1, lens, 0, sw, rl, d);
        chk("post-abort done cycle", d, 7);
        tick();

        // filter saturation and cfg writes ignored while busy
        clr();
        num_layers = 1; start = 1;
        tick();
        start = 0;
        wait_evt("wait sw sat", 0);
        tick();
        done_filter = 1; cfg_we = 1; cfg_addr = 3; cfg_data = ~mdl[3];
        repeat (1030) tick();
        done_filter = 0; cfg_we = 0;
        chk("filters_done saturate", filters_done, 1023);
        done_all = 1;
        tick();
        done_all = 0;
        wait_evt("sat run done", 1);
        tick();
        run(4, lens, 0, sw, rl, d);
        chk("table kept done cycle", d, 22);
        tick();

        // reset mid-run acts immediately
        num_layers = 2; start = 1;
        tick();
        start = 0;
        wait_evt("wait sw rst", 0);
        tick();
        rst = 1;
        #1;
        chk("rst conv_rst_n", conv_rst_n, 0);
        tick();
        chk("rst busy", busy, 0);
        chk("rst outputs", {cur_layer, dma_req, start_whole, stride, padding, kernel_size, input_channels}, 0);
        rst = 0;
        tick();
        chk("rst release conv_rst_n", conv_rst_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_layer_scheduler.md
CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 Parameter MAX_LAYERS, default 8, is the descriptor table depth.
REQ-002 Parameter IDX_W, default 3, is the layer index width, equal to log2(MAX_LAYERS).
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cfg_we  in  1  descriptor write strobe.
REQ-006 cfg_addr  in  IDX_W  descriptor index.
REQ-007 cfg_data  in  40  descriptor, packed as {stride[1:0], padding[2:0], kernel_size[4:0], input_channels[9:0], filter_number[9:0], temporal_length[9:0]}, MSB first.
REQ-008 num_layers  in  IDX_W+1  number of layers to run, sampled on start.
REQ-009 start  in  1  one-cycle run request.
REQ-010 abort  in  1  one-cycle run cancel.
REQ-011 busy  out  1  a run is in progress.
REQ-012 done  out  1  one-cycle pulse at run end.
REQ-013 cur_layer  out  IDX_W  index of the active layer.
REQ-014 filters_done  out  10  done_filter pulses seen in the current layer.
REQ-015 stride / padding / kernel_size / input_channels / filter_number / temporal_length  out  2/3/5/10/10/10  registered layer parameters to the 1D-conv control.
REQ-016 conv_rst_n  out  1  active-low reset to the 1D-conv control.
REQ-017 start_whole  out  1  one-cycle start pulse to the 1D-conv control.
REQ-018 done_all / done_filter  in  1/1  completion pulses from the 1D-conv control.
REQ-019 weight_req_top  in  1  level weight-reload request from the 1D-conv control.
REQ-020 weight_ack_top  out  1  one-cycle acknowledge to the 1D-conv control.
REQ-021 dma_req  out  1  level weight request to the DMA.
REQ-022 dma_layer  out  IDX_W  layer index accompanying dma_req.
REQ-023 dma_ack  in  1  one-cycle DMA completion.

Function
REQ-024 The FSM states shall be IDLE, CLR, CFG, GO, RUN, WREQ, NEXT and FIN.
REQ-025 IDLE: start with num_layers=0 shall go to FIN; start with num_layers 1..MAX_LAYERS shall latch num_layers, set cur_layer=0 and go to CLR; num_layers>MAX_LAYERS shall be clamped to MAX_LAYERS.
REQ-026 CLR: conv_rst_n shall be 0 for exactly this one cycle, filters_done shall clear, and the FSM shall go to CFG.
REQ-027 CFG: the layer parameter outputs shall load from table[cur_layer], and the FSM shall go to GO.
REQ-028 GO: start_whole shall be 1 for this one cycle, and the FSM shall go to RUN.
REQ-029 RUN: a weight_req_top rising edge shall set dma_req=1, set dma_layer=cur_layer and go to WREQ; done_all shall go to NEXT; each done_filter shall increment filters_done, saturating at 1023.
REQ-030 WREQ: dma_req shall hold until dma_ack. On the dma_ack cycle: dma_req shall drop, weight_ack_top shall pulse one cycle later, and the FSM shall return to RUN. done_filter shall still count in WREQ.
REQ-031 If weight_req_top and done_all occur in the same RUN cycle, done_all shall win and the request shall be dropped.
REQ-032 NEXT: if cur_layer+1 = latched num_layers, go to FIN; otherwise increment cur_layer and go to CLR.
REQ-033 FIN: done shall be 1 for one cycle, and the FSM shall go to IDLE.
REQ-034 busy shall be 1 in every state except IDLE.
REQ-035 start while busy shall be ignored.
REQ-036 cfg_we while busy shall be ignored; cfg_we in IDLE shall write the table in one cycle.
REQ-037 abort in any non-IDLE state shall force CLR-style conv_rst_n=0 for one cycle, clear dma_req, and return to IDLE with no done pulse. abort in IDLE shall have no effect. abort has priority over all other events in that cycle.
REQ-038 Layer parameter outputs shall hold their value outside CFG.
REQ-039 Latency from start to the first start_whole shall be 3 cycles (IDLE→CLR→CFG→GO). Latency from done_all to the next layer's start_whole shall be 4 cycles.

Reset
REQ-040 On rst, the FSM shall enter IDLE, and the following outputs shall be 0: busy, done, cur_layer, filters_done, all layer parameters, start_whole, weight_ack_top, dma_req and dma_layer.
REQ-041 On rst, conv_rst_n shall be 0 during reset and return to 1 on the first cycle after rst deasserts.
REQ-042 Descriptor table contents are not reset, and reads of unwritten entries are don't-care.
REQ-043 rst mid-run shall behave as abort but take effect immediately.

Structure
REQ-044 A shared package shall hold the state encoding, the descriptor field offsets and widths, and MAX_LAYERS.
REQ-045 The descriptor table shall be one sub-module, layer_desc_regfile: MAX_LAYERS x 40 bits, 1 write port, 1 asynchronous read port.

Verification
REQ-046 Load 2 descriptors (stride 1, kernel 5, filter_number 4 / stride 2, kernel 3, filter_number 8), run num_layers=2 → 2 start_whole pulses, cur_layer goes 0→1, exactly 1 done pulse, parameters match each descriptor in RUN.
REQ-047 num_layers=0 → done two cycles after start, no start_whole, conv_rst_n stays 1.
REQ-048 weight_req_top raised in layer 1, dma_ack 10 cycles later → dma_req high for exactly 10 cycles with dma_layer=1, and weight_ack_top pulses 1 cycle after dma_ack.
REQ-049 weight_req_top rise coincident with done_all → no dma_req, FSM advances to NEXT.
REQ-050 abort during WREQ → dma_req=0 next cycle, one conv_rst_n low cycle, busy=0, no done pulse; a subsequent start runs normally.
REQ-051 1030 done_filter pulses in one layer → filters_done saturates at 1023; cfg_we during RUN leaves the table unchanged.
